// File: rtl/mru_pkg.sv
// rtl/mru_pkg.sv - shared types, ID range and LED decode for the MRU player
package mru_pkg;
  typedef enum logic [1:0] {IDLE, SHOW, GAP, DONE} state_t;

  localparam int ID_W   = 3;
  localparam int ID_MIN = 1;
  localparam int ID_MAX = 4;

  // Button ID to one-hot LED vector {l4, l3, l2, l1}; out-of-range IDs light nothing.
  function automatic logic [3:0] id_to_led(input logic [ID_W-1:0] id);
    case (id)
      3'd1:    id_to_led = 4'b0001;
      3'd2:    id_to_led = 4'b0010;
      3'd3:    id_to_led = 4'b0100;
      3'd4:    id_to_led = 4'b1000;
      default: id_to_led = 4'b0000;
    endcase
  endfunction
endpackage

// File: rtl/mru_player_if.sv
// rtl/mru_player_if.sv - push/play request and LED/status bundle of the MRU player
interface mru_player_if #(
  parameter int DEPTH = 3
);
  import mru_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic            push_valid;
  logic [ID_W-1:0] push_id;
  logic            play;
  logic            l1;
  logic            l2;
  logic            l3;
  logic            l4;
  logic            busy;
  logic            done;
  logic [CNT_W-1:0] count;

  modport master (
    output push_valid, push_id, play,
    input  l1, l2, l3, l4, busy, done, count
  );

  modport slave (
    input  push_valid, push_id, play,
    output l1, l2, l3, l4, busy, done, count
  );
endinterface

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running divider emitting a one-cycle tick every TICK_DIV clocks
module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/mru_player.sv
// rtl/mru_player.sv - bounded most-recent-first push history replayed newest-first onto four LEDs
module mru_player
  import mru_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int TICK_DIV   = 4,
  parameter int HOLD_TICKS = 2
) (
  input  logic        clk,
  input  logic        rst,
  mru_player_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int HW    = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  logic             tick;
  state_t           state;
  logic [ID_W-1:0]  hist [DEPTH];
  logic [CNT_W-1:0] count;
  logic [HW-1:0]    hold;
  logic [3:0]       led;
  logic             busy;
  logic             done;
  logic             push_ok;
  logic             full;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign full    = (count == CNT_W'(DEPTH));
  assign push_ok = (state == IDLE) && bus.push_valid &&
                   (bus.push_id >= ID_W'(ID_MIN)) && (bus.push_id <= ID_W'(ID_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      hold  <= '0;
      led   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (push_ok) begin
            for (int i = DEPTH - 1; i > 0; i--) hist[i] <= hist[i-1];
            hist[0] <= bus.push_id;
            if (!full) count <= count + CNT_W'(1);
          end
          // A same-cycle push lands first, so it becomes the first entry shown.
          if (bus.play) begin
            busy <= 1'b1;
            hold <= '0;
            if (push_ok || (count != '0)) begin
              state <= SHOW;
              led   <= id_to_led(push_ok ? bus.push_id : hist[0]);
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        SHOW: begin
          if (tick) begin
            if (hold == HW'(HOLD_TICKS - 1)) begin
              for (int i = 0; i < DEPTH - 1; i++) hist[i] <= hist[i+1];
              hist[DEPTH-1] <= '0;
              count <= count - CNT_W'(1);
              led   <= '0;
              state <= GAP;
            end else begin
              hold <= hold + HW'(1);
            end
          end
        end
        GAP: begin
          if (tick) begin
            if (count != '0) begin
              state <= SHOW;
              hold  <= '0;
              led   <= id_to_led(hist[0]);
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.l1    = led[0];
  assign bus.l2    = led[1];
  assign bus.l3    = led[2];
  assign bus.l4    = led[3];
  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.count = count;
endmodule
